// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing a generic 8-bit read/write register file plus a read-only status window.
module i2c_slave_regfile #(
  parameter logic [6:0]  i2c_address = 7'h69,
  parameter int unsigned NUM_RW      = 16,
  parameter int unsigned NUM_RO      = 4,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       scl_i,
  input  logic                                       sda_i,
  output logic                                       sda_oe,
  output logic [NUM_RW*8-1:0]                        rw_regs,
  input  logic [((NUM_RO > 0) ? NUM_RO*8 : 8)-1:0]   ro_data,
  output logic                                       wr_strobe,
  output logic [6:0]                                 wr_index,
  output logic                                       busy
);

  localparam int unsigned TOTAL    = NUM_RW + NUM_RO;
  localparam logic [2:0]  FILT_MAX = 3'(FILT_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic [2:0] scl_cnt_q, sda_cnt_q;
  logic       scl_f_q, sda_f_q, scl_prev_q, sda_prev_q;
  logic       scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] tx_q, ptr_q;
  logic       phase_q, read_q;
  logic       sda_oe_q, busy_q, wr_strobe_q;
  logic [6:0] wr_index_q;
  logic [7:0] regs_q [NUM_RW];
  logic [7:0] rx_byte, rd_byte, ptr_next;

  // Synchronise both pins, then only accept a new level after FILT_LEN equal samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      if (scl_sync_q[1] == scl_f_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == FILT_MAX) begin
        scl_f_q   <= scl_sync_q[1];
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 3'd1;
      end
      if (sda_sync_q[1] == sda_f_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == FILT_MAX) begin
        sda_f_q   <= sda_sync_q[1];
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 3'd1;
      end
      scl_prev_q <= scl_f_q;
      sda_prev_q <= sda_f_q;
    end
  end

  always_comb begin
    scl_rise  = scl_f_q & ~scl_prev_q;
    scl_fall  = ~scl_f_q & scl_prev_q;
    start_det = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
    stop_det  = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;
    rx_byte   = {shift_q, sda_f_q};
    ptr_next  = (ptr_q == 8'(TOTAL - 1)) ? '0 : ptr_q + 8'd1;
  end

  always_comb begin
    rd_byte = '0;
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (ptr_q == 8'(i)) rd_byte = regs_q[i];
    end
    for (int unsigned i = 0; i < NUM_RO; i++) begin
      if (ptr_q == 8'(NUM_RW + i)) rd_byte = ro_data[i*8 +: 8];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      rw_regs[i*8 +: 8] = regs_q[i];
    end
  end

  // Protocol FSM; START/STOP override any SCL-edge activity in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      phase_q     <= 1'b0;
      read_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
      for (int unsigned i = 0; i < NUM_RW; i++) regs_q[i] <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (start_det) begin
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        phase_q   <= 1'b0;
        sda_oe_q  <= 1'b0;
      end else if (stop_det) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        phase_q   <= 1'b0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        unique case (state_q)
          ADDR: if (scl_rise) begin
            shift_q   <= rx_byte[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte[7:1] == i2c_address) begin
                busy_q  <= 1'b1;
                read_q  <= rx_byte[0];
                state_q <= ADDR_ACK;
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          // The ACK slot spans two falling edges: assert on the first, release on the second.
          // For reads, the release edge also launches the MSB of the first byte.
          ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_q <= 1'b1;
              phase_q  <= 1'b1;
            end else begin
              phase_q   <= 1'b0;
              bit_cnt_q <= '0;
              if (state_q == ADDR_ACK && read_q) begin
                tx_q     <= {rd_byte[6:0], 1'b0};
                sda_oe_q <= ~rd_byte[7];
                ptr_q    <= ptr_next;
                state_q  <= RDATA;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= (state_q == ADDR_ACK) ? PTR : WDATA;
              end
            end
          end
          PTR: if (scl_rise) begin
            shift_q   <= rx_byte[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (32'(rx_byte) < TOTAL) begin
                ptr_q   <= rx_byte;
                state_q <= PTR_ACK;
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          WDATA: if (scl_rise) begin
            shift_q   <= rx_byte[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              for (int unsigned i = 0; i < NUM_RW; i++) begin
                if (ptr_q == 8'(i)) regs_q[i] <= rx_byte;
              end
              if (32'(ptr_q) < NUM_RW) begin
                wr_strobe_q <= 1'b1;
                wr_index_q  <= ptr_q[6:0];
              end
              ptr_q   <= ptr_next;
              state_q <= WDATA_ACK;
            end
          end
          RDATA: begin
            if (scl_fall) begin
              sda_oe_q <= ~tx_q[7];
              tx_q     <= {tx_q[6:0], 1'b0};
            end else if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                phase_q <= 1'b0;
                state_q <= RDATA_ACK;
              end
            end
          end
          // Release on the falling edge after bit 8, then sample the master's ACK/NACK.
          RDATA_ACK: begin
            if (scl_fall && !phase_q) begin
              sda_oe_q <= 1'b0;
              phase_q  <= 1'b1;
            end else if (scl_rise && phase_q) begin
              phase_q <= 1'b0;
              if (sda_f_q) begin
                state_q <= IGNORE;
              end else begin
                tx_q      <= rd_byte;
                ptr_q     <= ptr_next;
                bit_cnt_q <= '0;
                state_q   <= RDATA;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;

endmodule
